// File: rtl/sphere_bank.sv
// sphere_bank: physics/state store for N_SPHERES falling spheres.
//   Holds position, velocity and colour for every sphere.
//   On each frame tick it walks the spheres, one per Clk cycle.
//   During the walk each sphere either integrates gravity or is respawned.
//   A respawn happens on floor exit or on a pending Hit.
//   The tracer reads one sphere per cycle by index.
// Ports:
//   Clk, Reset      system clock, asynchronous active-high reset
//   Frame_Clk       frame tick, asynchronous to Clk
//   Hit, Hit_index  request respawn of one sphere
//   Read_index      sphere to read; Sphere_pos/Sphere_col/curr_index follow one cycle later
//   Busy            update walk in progress
//   Frame_done      1-cycle pulse at the end of a walk
//   Overrun         1-cycle pulse when a frame edge was dropped because a walk was running

// sphere_bank_lane: state of one sphere (position, velocity, colour, pending hit).
//   sel      this sphere is being processed this cycle
//   hit_set  Hit addressed to this sphere this cycle
//   spawn_x  respawn X coordinate, taken from the LFSR
//   spawn_col respawn colour, taken from the LFSR
//   pos, col current state, read by the top-level read mux
module sphere_bank_lane #(
   parameter int           W         = 64,
   parameter logic [W-1:0] GRAVITY   = '0,
   parameter logic [W-1:0] FLOOR     = '0,
   parameter logic [W-1:0] SPAWN_Y   = '0,
   parameter logic [W-1:0] SPAWN_Z   = '0,
   parameter logic [W-1:0] INIT_Z    = '0,
   parameter logic [23:0]  COL_RESET = 24'h808080
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                sel,
   input  logic                hit_set,
   input  logic [W-1:0]        spawn_x,
   input  logic [23:0]         spawn_col,
   output logic [2:0][W-1:0]   pos,
   output logic [23:0]         col
);
   localparam logic signed [W-1:0] NEG_FLOOR = -$signed(FLOOR);

   logic [2:0][W-1:0] vel, vel_n;
   logic              pending, respawn;

   // Floor test looks at the position before this frame's update.
   assign respawn = pending | hit_set | ($signed(pos[2]) < NEG_FLOOR);

   always_comb begin
      vel_n    = vel;
      vel_n[2] = vel[2] + GRAVITY;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pos     <= {SPAWN_Y, INIT_Z, {W{1'b0}}};
         vel     <= '0;
         col     <= COL_RESET;
         pending <= 1'b0;
      end else if (sel) begin
         // A hit landing on the sphere being processed is consumed right here.
         pending <= 1'b0;
         if (respawn) begin
            pos <= {SPAWN_Y, SPAWN_Z, spawn_x};
            vel <= '0;
            col <= spawn_col;
         end else begin
            vel <= vel_n;
            pos <= {pos[2] + vel_n[2], pos[1] + vel_n[1], pos[0] + vel_n[0]};
         end
      end else if (hit_set) begin
         pending <= 1'b1;
      end
   end
endmodule

module sphere_bank #(
   parameter int           N_SPHERES = 8,
   parameter int           IDX_W     = $clog2(N_SPHERES),
   parameter int           W         = 64,
   parameter int           FRAC      = 32,
   parameter logic [W-1:0] GRAVITY   = W'(-(64'sd4 << FRAC)),
   parameter logic [W-1:0] FLOOR     = W'(64'd2880 << FRAC),
   parameter logic [W-1:0] SPAWN_Y   = W'(-(64'sd2400 << FRAC)),
   parameter logic [W-1:0] SPAWN_Z   = W'(64'd4800 << FRAC),
   parameter logic [W-1:0] SPACING   = W'(64'd4800 << FRAC),
   parameter logic [63:0]  LFSR_SEED = 64'hACE1_F00D_1234_5678,
   parameter logic [23:0]  COL_RESET = 24'h808080
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Frame_Clk,
   input  logic               Hit,
   input  logic [IDX_W-1:0]   Hit_index,
   input  logic [IDX_W-1:0]   Read_index,
   output logic [3*W-1:0]     Sphere_pos,
   output logic [23:0]        Sphere_col,
   output logic [IDX_W-1:0]   curr_index,
   output logic               Busy,
   output logic               Frame_done,
   output logic               Overrun
);
   localparam int              KW        = $clog2(N_SPHERES);
   localparam logic [KW-1:0]   K_LAST    = KW'(N_SPHERES - 1);
   localparam logic [IDX_W:0]  N_CMP     = (IDX_W + 1)'(N_SPHERES);
   // Galois mask for x^64 + x^63 + x^61 + x^60 + 1, right-shifting form.
   localparam logic [63:0]     LFSR_MASK = 64'hD800_0000_0000_0000;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_UPDATE = 1'b1;

   logic [0:0]              state;
   logic [KW-1:0]           k;
   logic [63:0]             lfsr;
   logic [2:0]              fsync;
   logic                    frame_edge;
   logic                    hit_ok, rd_ok;
   logic [KW-1:0]           hit_lo, rd_lo;
   logic [W-1:0]            spawn_x;
   logic [N_SPHERES-1:0]    sel, hit_set;
   logic [2:0][W-1:0]       lane_pos [N_SPHERES];
   logic [23:0]             lane_col [N_SPHERES];
   logic                    unused_lfsr;

   assign unused_lfsr = ^{lfsr[63:48], lfsr[23:12]};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) lfsr <= LFSR_SEED;
      else       lfsr <= {1'b0, lfsr[63:1]} ^ (lfsr[0] ? LFSR_MASK : 64'd0);
   end

   // fsync[1:0] is the 2-FF synchroniser; fsync[2] holds the previous value for edge detect.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) fsync <= '0;
      else       fsync <= {fsync[1:0], Frame_Clk};
   end
   assign frame_edge = fsync[1] & ~fsync[2];

   assign Busy = (state == S_UPDATE);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= S_IDLE;
         k          <= '0;
         Frame_done <= 1'b0;
         Overrun    <= 1'b0;
      end else begin
         Frame_done <= 1'b0;
         Overrun    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (frame_edge) begin
                  state <= S_UPDATE;
                  k     <= '0;
               end
            end
            default: begin
               // Edges arriving mid-walk are dropped, only flagged.
               if (frame_edge) Overrun <= 1'b1;
               if (k == K_LAST) begin
                  state      <= S_IDLE;
                  k          <= '0;
                  Frame_done <= 1'b1;
               end else begin
                  k <= k + KW'(1);
               end
            end
         endcase
      end
   end

   assign hit_ok  = Hit && ({1'b0, Hit_index} < N_CMP);
   assign hit_lo  = Hit_index[KW-1:0];
   assign rd_ok   = ({1'b0, Read_index} < N_CMP);
   assign rd_lo   = Read_index[KW-1:0];
   assign spawn_x = {{(W-12){lfsr[11]}}, lfsr[11:0]} << FRAC;

   for (genvar i = 0; i < N_SPHERES; i++) begin : g_lane
      localparam logic [W-1:0] INIT_Z = SPAWN_Z + SPACING * W'(i);
      assign sel[i]     = Busy && (k == KW'(i));
      assign hit_set[i] = hit_ok && (hit_lo == KW'(i));
      sphere_bank_lane #(
         .W(W), .GRAVITY(GRAVITY), .FLOOR(FLOOR), .SPAWN_Y(SPAWN_Y),
         .SPAWN_Z(SPAWN_Z), .INIT_Z(INIT_Z), .COL_RESET(COL_RESET)
      ) u_lane (
         .Clk(Clk), .Reset(Reset), .sel(sel[i]), .hit_set(hit_set[i]),
         .spawn_x(spawn_x), .spawn_col(lfsr[47:24]),
         .pos(lane_pos[i]), .col(lane_col[i])
      );
   end

   // Registered read port; the lane registers update on the same edge, so a
   // sphere read in its update cycle returns its pre-update value.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Sphere_pos <= '0;
         Sphere_col <= '0;
         curr_index <= '0;
      end else begin
         curr_index <= Read_index;
         Sphere_pos <= rd_ok ? lane_pos[rd_lo] : '0;
         Sphere_col <= rd_ok ? lane_col[rd_lo] : '0;
      end
   end
endmodule
